// File: rtl/mtm_alu_deserializer_rx.sv
// Serial receiver for the ALU result link: rebuilds C and CTL from 11-bit frames.
// Optional CRC3 check of normal results is enabled by defining MTM_RX_CRC_CHECK_EN.
module mtm_alu_deserializer_rx #(
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sin,
    output logic [8*DATA_BYTES-1:0] C_out,
    output logic [7:0]              CTL_out,
    output logic                    valid,
    output logic                    err_only,
    output logic                    frame_err,
    output logic                    crc_err
);

    localparam int unsigned CW    = 8 * DATA_BYTES;
    localparam int unsigned CNT_W = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        PKT,
        DATA,
        STOP,
        RESYNC
    } state_t;

    state_t           state_q;
    logic             pkt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       byte_sr_q;
    logic [CW-1:0]    c_sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CW-1:0]    c_out_q;
    logic [7:0]       ctl_q;
    logic             valid_q;
    logic             err_only_q;
    logic             frame_err_q;
    logic             crc_err_q;
    logic             crc_bad_d;

`ifdef MTM_RX_CRC_CHECK_EN
    // Bit-serial CRC3 (x^3+x+1, init 0) over the message, MSB first.
    function automatic logic [2:0] crc3(input logic [CW+4:0] msg);
        logic [2:0] r;
        logic       fb;
        r = '0;
        for (int unsigned i = 0; i < CW + 5; i++) begin
            fb = r[2] ^ msg[CW+4-i];
            r  = {r[1], r[0] ^ fb, fb};
        end
        return r;
    endfunction

    always_comb begin
        crc_bad_d = (crc3({c_sr_q, 1'b0, byte_sr_q[6:3]}) != byte_sr_q[2:0]);
    end
`else
    always_comb begin
        crc_bad_d = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pkt_q       <= 1'b0;
            bit_cnt_q   <= '0;
            byte_sr_q   <= '0;
            c_sr_q      <= '0;
            cnt_q       <= '0;
            c_out_q     <= '0;
            ctl_q       <= '0;
            valid_q     <= 1'b0;
            err_only_q  <= 1'b0;
            frame_err_q <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_q <= PKT;
                    end
                end
                PKT: begin
                    pkt_q     <= sin;
                    bit_cnt_q <= '0;
                    state_q   <= DATA;
                end
                DATA: begin
                    byte_sr_q <= {byte_sr_q[6:0], sin};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (sin) begin
                        state_q <= IDLE;
                        if (!pkt_q) begin
                            if (cnt_q < CNT_FULL) begin
                                c_sr_q <= (c_sr_q << 8) | CW'(byte_sr_q);
                                cnt_q  <= cnt_q + CNT_W'(1);
                            end else begin
                                frame_err_q <= 1'b1;
                                cnt_q       <= '0;
                            end
                        end else begin
                            cnt_q <= '0;
                            if (cnt_q == CNT_FULL) begin
                                c_out_q    <= c_sr_q;
                                ctl_q      <= byte_sr_q;
                                err_only_q <= 1'b0;
                                crc_err_q  <= crc_bad_d;
                                valid_q    <= 1'b1;
                            end else if (cnt_q == '0 && byte_sr_q[7]) begin
                                c_out_q    <= '0;
                                ctl_q      <= byte_sr_q;
                                err_only_q <= 1'b1;
                                crc_err_q  <= 1'b0;
                                valid_q    <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= RESYNC;
                    end
                end
                RESYNC: begin
                    if (sin) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign C_out     = c_out_q;
    assign CTL_out   = ctl_q;
    assign valid     = valid_q;
    assign err_only  = err_only_q;
    assign frame_err = frame_err_q;
    assign crc_err   = crc_err_q;

endmodule

// File: tb/tb_mtm_alu_deserializer_rx.sv
// Directed bench for mtm_alu_deserializer_rx with an expected-event scoreboard.
// Define MTM_RX_CRC_CHECK_EN for both DUT and bench to cover the CRC check.
module tb_mtm_alu_deserializer_rx;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic [31:0] C_out;
    logic [7:0]  CTL_out;
    logic        valid;
    logic        err_only;
    logic        frame_err;
    logic        crc_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          is_valid;
        logic [31:0] c;
        logic [7:0]  ctl;
        logic        eo;
        logic        ce;
    } exp_t;

    exp_t        sb[$];
    int          m_cnt = 0;
    logic [31:0] m_c   = '0;

    mtm_alu_deserializer_rx #(.DATA_BYTES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sin      (sin),
        .C_out    (C_out),
        .CTL_out  (CTL_out),
        .valid    (valid),
        .err_only (err_only),
        .frame_err(frame_err),
        .crc_err  (crc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // CRC3 by long division of {msg, 3'b0} by x^3+x+1.
    function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] nib);
        logic [39:0] r;
        r = {c, 1'b0, nib, 3'b000};
        for (int i = 39; i >= 3; i--) begin
            if (r[i]) r[i-:4] = r[i-:4] ^ 4'b1011;
        end
        return r[2:0];
    endfunction

    function automatic logic [7:0] make_ctl(input logic [31:0] c, input logic [3:0] nib);
        return {1'b0, nib, ref_crc(c, nib)};
    endfunction

    task automatic push_ferr();
        exp_t e;
        e = '{is_valid: 1'b0, c: '0, ctl: '0, eo: 1'b0, ce: 1'b0};
        sb.push_back(e);
    endtask

    task automatic push_valid(input logic [31:0] c, input logic [7:0] ctl, input logic eo, input logic ce);
        exp_t e;
        e = '{is_valid: 1'b1, c: c, ctl: ctl, eo: eo, ce: ce};
        sb.push_back(e);
    endtask

    // Receiver model: what a complete frame should produce.
    task automatic model_frame(input logic pkt, input logic [7:0] b, input logic stop);
        logic ce;
        if (!stop) begin
            push_ferr();
            m_cnt = 0;
        end else if (!pkt) begin
            if (m_cnt < 4) begin
                m_c = {m_c[23:0], b};
                m_cnt++;
            end else begin
                push_ferr();
                m_cnt = 0;
            end
        end else begin
            if (m_cnt == 4) begin
`ifdef MTM_RX_CRC_CHECK_EN
                ce = (ref_crc(m_c, b[6:3]) != b[2:0]);
`else
                ce = 1'b0;
`endif
                push_valid(m_c, b, 1'b0, ce);
            end else if (m_cnt == 0 && b[7]) begin
                push_valid(32'h0, b, 1'b1, 1'b0);
            end else begin
                push_ferr();
            end
            m_cnt = 0;
        end
    endtask

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_frame(input logic pkt, input logic [7:0] b, input logic stop);
        model_frame(pkt, b, stop);
        send_bit(1'b0);
        send_bit(pkt);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_result(input logic [31:0] c, input logic [7:0] ctl);
        for (int i = 3; i >= 0; i--) send_frame(1'b0, c[8*i+:8], 1'b1);
        send_frame(1'b1, ctl, 1'b1);
    endtask

    // Output monitor: every valid / frame_err pulse must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && (valid || frame_err)) begin
            exp_t e;
            check("valid_ferr_exclusive", {63'b0, valid & frame_err}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_event", {62'b0, valid, frame_err}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("event_kind", {63'b0, valid}, {63'b0, e.is_valid});
                if (e.is_valid && valid) begin
                    check("C_out", {32'b0, C_out}, {32'b0, e.c});
                    check("CTL_out", {56'b0, CTL_out}, {56'b0, e.ctl});
                    check("err_only", {63'b0, err_only}, {63'b0, e.eo});
                    check("crc_err", {63'b0, crc_err}, {63'b0, e.ce});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bad_ctl;
        logic [31:0] c2;
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_C_out", {32'b0, C_out}, 64'd0);
        check("rst_CTL_out", {56'b0, CTL_out}, 64'd0);
        check("rst_valid", {63'b0, valid}, 64'd0);
        check("rst_err_only", {63'b0, err_only}, 64'd0);
        check("rst_frame_err", {63'b0, frame_err}, 64'd0);
        check("rst_crc_err", {63'b0, crc_err}, 64'd0);
        rst_n = 1'b1;
        send_idle(3);

        check("ref_ctl_0x2A", {56'b0, make_ctl(32'h12345678, 4'b0101)}, 64'h2A);
        send_result(32'h12345678, 8'h2A);
        send_idle(2);

        send_frame(1'b1, 8'hC9, 1'b1);
        send_idle(2);

        send_frame(1'b0, 8'h11, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0);
        send_idle(3);
        check("hold_C_out_after_ferr", {32'b0, C_out}, 64'd0);
        check("hold_CTL_out_after_ferr", {56'b0, CTL_out}, 64'hC9);
        send_result(32'hCAFE0123, make_ctl(32'hCAFE0123, 4'b1001));
        send_idle(2);

        for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'h30 + i), 1'b1);
        send_frame(1'b1, 8'h2A, 1'b1);
        send_idle(2);

        for (int i = 0; i < 3; i++) send_frame(1'b0, 8'(8'h40 + i), 1'b1);
        send_frame(1'b1, 8'h2A, 1'b1);
        send_idle(2);

        send_frame(1'b1, 8'h55, 1'b1);
        send_idle(1);
        send_result(32'h0BADF00D, 8'hFF);
        send_idle(2);

        send_result(32'hA5A50F0F, make_ctl(32'hA5A50F0F, 4'b0011));
        send_result(32'hDEADBEEF, make_ctl(32'hDEADBEEF, 4'b1110));
        send_frame(1'b1, 8'h81, 1'b1);
        send_idle(3);

        send_frame(1'b0, 8'h01, 1'b1);
        send_frame(1'b0, 8'h02, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        m_cnt = 0;
        #2;
        check("midrst_C_out", {32'b0, C_out}, 64'd0);
        check("midrst_CTL_out", {56'b0, CTL_out}, 64'd0);
        check("midrst_err_only", {63'b0, err_only}, 64'd0);
        check("midrst_valid", {63'b0, valid}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sin   = 1'b1;
        send_idle(2);
        send_result(32'h87654321, make_ctl(32'h87654321, 4'b0110));
        send_idle(2);

        c2      = 32'h12345678;
        bad_ctl = 8'h2A ^ 8'h07;
        send_result(c2, bad_ctl);
        send_idle(2);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        send_idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
